// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        CD_IDLE,
        CD_RUN,
        CD_DONE
    } cd_state_t;

    localparam int unsigned CD_DEF_DWIDTH   = 5;
    localparam int unsigned CD_DEF_DEC_SIZE = 1;

endpackage

// File: rtl/countdown_timer.sv
// Loadable saturating down-counter with a valid/ready start handshake and a one-cycle
// done pulse at expiry.
// Optional: define COUNTDOWN_AUTO_RELOAD_EN to add reload_en and a reload register that
// restarts the countdown from the last accepted load value after each expiry.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned DWIDTH   = CD_DEF_DWIDTH,
    parameter int unsigned DEC_SIZE = CD_DEF_DEC_SIZE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DWIDTH-1:0] load_value,
    input  logic              pause,
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    input  logic              reload_en,
`endif
    output logic [DWIDTH-1:0] count,
    output logic              busy,
    output logic              done
);

    localparam logic [DWIDTH-1:0] DecStep = DWIDTH'(DEC_SIZE);

    cd_state_t         state_q, state_d;
    logic [DWIDTH-1:0] count_q, count_d;
    logic              start_fire;

    assign start_fire = start_valid && start_ready;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [DWIDTH-1:0] reload_q, reload_d;

    // Reload value follows every accepted start.
    always_comb begin
        reload_d = reload_q;
        if (start_fire) begin
            reload_d = load_value;
        end
    end

    // Reload register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    // State and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CD_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CD_IDLE: begin
                if (start_fire) begin
                    state_d = (load_value == '0) ? CD_DONE : CD_RUN;
                end
            end
            CD_RUN: begin
                if (!pause && (count_q <= DecStep)) begin
                    state_d = CD_DONE;
                end
            end
            CD_DONE: begin
                state_d = CD_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (reload_en) begin
                    state_d = (reload_q == '0) ? CD_DONE : CD_RUN;
                end
`endif
            end
            default: state_d = CD_IDLE;
        endcase
    end

    // Count datapath: load on start, saturating decrement in RUN, zero in DONE.
    always_comb begin
        count_d = count_q;
        unique case (state_q)
            CD_IDLE: begin
                if (start_fire) begin
                    count_d = load_value;
                end
            end
            CD_RUN: begin
                if (!pause) begin
                    // Unsigned compare keeps the final step from wrapping below zero.
                    count_d = (count_q <= DecStep) ? '0 : (count_q - DecStep);
                end
            end
            CD_DONE: begin
                count_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (reload_en) begin
                    count_d = reload_q;
                end
`endif
            end
            default: count_d = '0;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        start_ready = (state_q == CD_IDLE);
        busy        = (state_q != CD_IDLE);
        done        = (state_q == CD_DONE);
        count       = count_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: two instances (DEC_SIZE 1 and 3) driven with the
// same directed and random stimulus, checked every cycle against a transaction-level model.
// Follows COUNTDOWN_AUTO_RELOAD_EN when defined.
module tb_countdown_timer;

    localparam int unsigned DW = 5;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit ReloadBuild = 1'b1;
`else
    localparam bit ReloadBuild = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_valid = 1'b0;
    logic          pause = 1'b0;
    logic          reload_en = 1'b0;
    logic [DW-1:0] load_value = '0;

    logic [DW-1:0] cnt [2];
    logic          rdy [2];
    logic          bsy [2];
    logic          dn  [2];

    int errors = 0;
    int checks = 0;

    // Model: per DUT, whether a countdown is active, its load N, the number of unpaused
    // countdown cycles taken, and the last accepted load (for reload).
    bit act   [2];
    int n     [2];
    int steps [2];
    int rld   [2];

    always #5 clk = ~clk;

    countdown_timer #(.DWIDTH(DW), .DEC_SIZE(1)) u_dut0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_valid (start_valid),
        .start_ready (rdy[0]),
        .load_value  (load_value),
        .pause       (pause),
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        .reload_en   (reload_en),
`endif
        .count       (cnt[0]),
        .busy        (bsy[0]),
        .done        (dn[0])
    );

    countdown_timer #(.DWIDTH(DW), .DEC_SIZE(3)) u_dut1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_valid (start_valid),
        .start_ready (rdy[1]),
        .load_value  (load_value),
        .pause       (pause),
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        .reload_en   (reload_en),
`endif
        .count       (cnt[1]),
        .busy        (bsy[1]),
        .done        (dn[1])
    );

    function automatic int dec_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Cycles of unpaused countdown needed to reach zero.
    function automatic int need_of(int nn, int d);
        return (nn + d - 1) / d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            act[i]   = 1'b0;
            n[i]     = 0;
            steps[i] = 0;
            rld[i]   = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!act[i]) begin
                if (start_valid) begin
                    act[i]   = 1'b1;
                    n[i]     = int'(load_value);
                    steps[i] = 0;
                    rld[i]   = int'(load_value);
                end
            end else if (steps[i] == need_of(n[i], dec_of(i))) begin
                if (ReloadBuild && reload_en) begin
                    n[i]     = rld[i];
                    steps[i] = 0;
                end else begin
                    act[i] = 1'b0;
                end
            end else if (!pause) begin
                steps[i]++;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int rem;
        for (int i = 0; i < 2; i++) begin
            rem = n[i] - steps[i] * dec_of(i);
            if (rem < 0 || !act[i]) rem = 0;
            chk($sformatf("d%0d.count", i), 32'(cnt[i]), 32'(rem));
            chk($sformatf("d%0d.done", i), 32'(dn[i]),
                32'(act[i] && steps[i] == need_of(n[i], dec_of(i))));
            chk($sformatf("d%0d.busy", i), 32'(bsy[i]), 32'(act[i]));
            chk($sformatf("d%0d.start_ready", i), 32'(rdy[i]), 32'(!act[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    task automatic start(int v);
        start_valid = 1'b1;
        load_value  = DW'(v);
        step();
        start_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        step();
        step();
        #2 reset_n = 1'b1;
        step();

        // Plain countdown from 5.
        start(5);
        repeat (8) step();

        // Zero load goes straight to DONE.
        start(0);
        repeat (3) step();

        // Load 7: DEC_SIZE 3 instance saturates 7,4,1,0.
        start(7);
        repeat (9) step();

        // Pause two cycles mid-run while a stray start of 9 is offered.
        start(4);
        step();
        pause       = 1'b1;
        start_valid = 1'b1;
        load_value  = DW'(9);
        step();
        step();
        pause       = 1'b0;
        start_valid = 1'b0;
        repeat (6) step();

        // Maximum load, then asynchronous reset mid-run: no done pulse.
        start(31);
        repeat (3) step();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
        #2 reset_n = 1'b1;
        repeat (3) step();

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Periodic expiry with reload, then drop reload_en.
        reload_en = 1'b1;
        start(3);
        repeat (12) step();
        reload_en = 1'b0;
        repeat (8) step();
`endif

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            start_valid = 1'($urandom_range(0, 1));
            load_value  = DW'($urandom_range(0, 31));
            pause       = ($urandom_range(0, 3) == 0);
            if (ReloadBuild) reload_en = ($urandom_range(0, 3) == 0);
            step();
        end
        start_valid = 1'b0;
        pause       = 1'b0;
        reload_en   = 1'b0;
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
